dac_spi_master: RTL and testbench
=================================

// Module: dac_spi_master
// PURPOSE
//  SPI command initiator for the DACx0504 24-bit serial interface, running directly on DAC_CLK (12.5 MHz).
//  Accepts register write/read commands from FPGA control logic, serialises 24-bit frames on DAC_SDI/DAC_CS_N, and returns readback data.
//  DAC_CLK is also the free-running SCLK at the pin; the DAC samples on the rising edge.
//  A read is issued as a read frame followed automatically by a NOP echo frame; the echo frame clocks out DAC_SDO.
// PARAMETERS
//  CS_GAP   2  DAC_CLK cycles DAC_CS_N held high between frames (min 1; values <1 are treated as 1)
//  ECHO_CMD 24'h000000  frame sent during the readback (echo) frame
// PORTS
//  DAC_CLK    in   1   clock; all logic on rising edge
//  SYS_RST    in   1   reset, asynchronous, active-high
//  cmd_valid  in   1   command request
//  cmd_ready  out  1   high only in IDLE; transfer = cmd_valid & cmd_ready
//  cmd_rd     in   1   1 = read, 0 = write
//  cmd_addr   in   4   register address (0x0..0xB legal)
//  cmd_data   in   16  write data (ignored for reads)
//  rsp_valid  out  1   1-cycle pulse: readback complete
//  rsp_data   out  16  readback data, held until next rsp_valid
//  rsp_err    out  1   valid with rsp_valid: echo header != {4'h8, cmd_addr}
//  busy       out  1   high from command accept until return to IDLE
//  DAC_CS_N   out  1   chip select, active low
//  DAC_SDI    out  1   serial data to DAC, MSB first
//  DAC_SDO    in   1   serial data from DAC
// BEHAVIOUR
//  Reset: DAC_CS_N=1, DAC_SDI=0, cmd_ready=1 (after reset release), busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE.
//  Frame word: {rd, 3'b000, addr[3:0], data[15:0]}; reads send data=16'h0000.
//  States: IDLE -> FRAME -> GAP -> (read & first frame ? FRAME(echo) : IDLE).
//  Frame timing, counted in edges E0..E26 with a 5-bit counter:
//   - E0 (accept edge): DAC_CS_N<=0; tx shift reg <= frame word; DAC_SDI <= bit23.
//   - E1: no change. The DAC uses this edge to arm its counter and does not sample data.
//   - E2..E24: DAC_SDI advances one bit per edge (bit22..bit0).
//   - E2..E25: rx shift reg <= {rx[22:0], DAC_SDO}, sampled at the same edges the DAC samples SDI.
//   - E25: hold DAC_CS_N low so the DAC's bit counter reaches 25 and commits the write.
//   - E26: DAC_CS_N<=1, DAC_SDI<=0. Exactly 26 DAC_CLK cycles of CS low per frame.
//  GAP: DAC_CS_N stays high CS_GAP cycles, which lets the DAC load its readback register. Next frame starts at the edge after the gap ends.
//  Read: frame1 = read cmd. After GAP, the echo frame (ECHO_CMD) starts with no new cmd handshake.
//   - At echo E26: rsp_data<=rx[15:0]; rsp_err<=(rx[23:16] != {4'h8,addr}); rsp_valid=1 for one cycle (the GAP-entry cycle).
//   - Busy stays high through the echo GAP.
//  Write: single frame + GAP; no rsp_valid.
//  cmd fields are registered at accept; later input changes have no effect mid-transaction.
//  Back-to-back: cmd_ready rises the cycle after GAP ends. Minimum command period: write 26+CS_GAP; read 2*(26+CS_GAP).
//  Illegal addr (>0xB) is still sent. A read returns rx = 0, so rsp_err=1 and rsp_data=0.
//  Asynchronous SYS_RST mid-frame: DAC_CS_N forced 1 immediately; the partial frame is dropped with no rsp_valid. The DAC never reaches bit count 25, so nothing is committed.
//  cmd_valid while busy: ignored, with no side effects.
// TESTING (bench: this block + DACx0504 slave model, SYS_CLK=100 MHz, DAC_CLK=12.5 MHz)
//  1. Write DAC0 (addr 8) data 0x1234 -> DAC_SDI stream 0x081234; CS low 26 cycles; slave REG_DAC0==0x1234; no rsp_valid.
//  2. Read DEVICE_ID (addr 1) after reset -> two CS frames, gap 2 cycles; rsp_valid once; rsp_data=0xABCD; rsp_err=0.
//  3. Write GAIN=0x0005, then read GAIN back-to-back (cmd_valid held) -> rsp_data=0x0005; second cmd_ready exactly 28 cycles after first accept.
//  4. Read addr 0xC -> rsp_valid with rsp_data=0x0000, rsp_err=1.
//  5. Assert SYS_RST at edge E12 of a DAC1 write of 0xBEEF -> DAC_CS_N=1 same time step; slave REG_DAC1 unchanged (0x3344 after reset); busy=0.
//  6. CS_GAP=1: read DAC3 -> rsp_data=0x7788; CS high exactly 1 cycle between the two frames.

Source files
------------

// File: rtl/dac_spi_master.sv
// SPI command initiator for the DACx0504 24-bit interface, clocked directly by DAC_CLK (also the pin SCLK).
// Writes are one frame; reads are a read frame plus an automatic echo frame that clocks back DAC_SDO.
module dac_spi_master #(
    parameter int          CS_GAP   = 2,
    parameter logic [23:0] ECHO_CMD = 24'h000000
) (
    input  logic        DAC_CLK,
    input  logic        SYS_RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [3:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        DAC_CS_N,
    output logic        DAC_SDI,
    input  logic        DAC_SDO
);

    localparam int          GAP_EFF  = (CS_GAP < 1) ? 1 : CS_GAP;
    localparam logic [15:0] GAP_LOAD = 16'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FRAME,
        ST_GAP
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_gap;
    logic [22:0] r_tx;
    logic [23:0] r_rx;
    logic        r_rd;
    logic [3:0]  r_addr;
    logic        r_echo;
    logic        r_ready;
    logic        r_busy;
    logic        r_cs_n;
    logic        r_sdi;
    logic        r_rsp_valid;
    logic [15:0] r_rsp_data;
    logic        r_rsp_err;

    logic        w_accept;
    logic [23:0] w_word;
    logic        w_echo_next;

    assign w_accept    = cmd_valid & r_ready;
    assign w_word      = {cmd_rd, 3'b000, cmd_addr, (cmd_rd ? 16'h0000 : cmd_data)};
    assign w_echo_next = r_rd & ~r_echo;

    always_ff @(posedge DAC_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_gap       <= '0;
            r_tx        <= '0;
            r_rx        <= '0;
            r_rd        <= 1'b0;
            r_addr      <= '0;
            r_echo      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_cs_n      <= 1'b1;
            r_sdi       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_FRAME;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_rd    <= cmd_rd;
                        r_addr  <= cmd_addr;
                        r_echo  <= 1'b0;
                        r_cs_n  <= 1'b0;
                        r_tx    <= w_word[22:0];
                        r_sdi   <= w_word[23];
                        r_cnt   <= 5'd1;
                    end
                end
                ST_FRAME: begin
                    r_cnt <= r_cnt + 5'd1;
                    // E1 is the DAC's arming edge: data only moves from E2 on
                    if (r_cnt >= 5'd2 && r_cnt <= 5'd24) begin
                        r_tx  <= {r_tx[21:0], 1'b0};
                        r_sdi <= r_tx[22];
                    end
                    if (r_cnt >= 5'd2 && r_cnt <= 5'd25) begin
                        r_rx <= {r_rx[22:0], DAC_SDO};
                    end
                    if (r_cnt == 5'd26) begin
                        r_cs_n <= 1'b1;
                        r_sdi  <= 1'b0;
                        r_gap  <= GAP_LOAD;
                        if (r_echo) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= r_rx[15:0];
                            r_rsp_err   <= (r_rx[23:16] != {4'h8, r_addr});
                        end
                        // A one-cycle gap before IDLE is covered by the IDLE cycle itself
                        if (w_echo_next || GAP_EFF > 1) begin
                            r_state <= ST_GAP;
                        end else begin
                            r_state <= ST_IDLE;
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_echo_next) begin
                        if (r_gap == 16'd0) begin
                            r_state <= ST_FRAME;
                            r_echo  <= 1'b1;
                            r_cs_n  <= 1'b0;
                            r_tx    <= ECHO_CMD[22:0];
                            r_sdi   <= ECHO_CMD[23];
                            r_cnt   <= 5'd1;
                        end else begin
                            r_gap <= r_gap - 16'd1;
                        end
                    end else if (r_gap <= 16'd1) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap <= r_gap - 16'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cs_n  <= 1'b1;
                    r_sdi   <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign DAC_CS_N  = r_cs_n;
    assign DAC_SDI   = r_sdi;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master: channel 0 uses CS_GAP=2, channel 1 uses CS_GAP=1,
// each with a DACx0504-style slave model holding register contents and driving DAC_SDO.
module tb_dac_spi_master;

    logic        DAC_CLK = 1'b0;
    logic        SYS_RST = 1'b1;
    int          cyc = 0;
    int          n_total = 0;
    int          n_bad = 0;

    logic        c_valid [2];
    logic        c_rd    [2];
    logic [3:0]  c_addr  [2];
    logic [15:0] c_data  [2];
    logic        ready_a [2];
    logic        rspv_a  [2];
    logic [15:0] rspd_a  [2];
    logic        rspe_a  [2];
    logic        busy_a  [2];
    logic        csn_a   [2];
    logic        sdi_a   [2];
    logic        sdo_a   [2];

    always #40 DAC_CLK = ~DAC_CLK;
    always @(negedge DAC_CLK) cyc++;

    for (genvar g = 0; g < 2; g++) begin : gch
        localparam int GAP = (g == 0) ? 2 : 1;

        dac_spi_master #(.CS_GAP(GAP), .ECHO_CMD(24'h000000)) u_dut (
            .DAC_CLK  (DAC_CLK),
            .SYS_RST  (SYS_RST),
            .cmd_valid(c_valid[g]),
            .cmd_ready(ready_a[g]),
            .cmd_rd   (c_rd[g]),
            .cmd_addr (c_addr[g]),
            .cmd_data (c_data[g]),
            .rsp_valid(rspv_a[g]),
            .rsp_data (rspd_a[g]),
            .rsp_err  (rspe_a[g]),
            .busy     (busy_a[g]),
            .DAC_CS_N (csn_a[g]),
            .DAC_SDI  (sdi_a[g]),
            .DAC_SDO  (sdo_a[g])
        );

        logic [15:0] sreg [16];
        logic [4:0]  n = '0;
        logic [23:0] sin = '0;
        logic [23:0] sout = '0;
        logic [23:0] last_frame = '0;

        initial begin
            for (int i = 0; i < 16; i++) sreg[i] = 16'h0000;
            sreg[1]  = 16'hABCD;
            sreg[4]  = 16'h0001;
            sreg[8]  = 16'h1111;
            sreg[9]  = 16'h3344;
            sreg[11] = 16'h7788;
        end

        // Slave: samples SDI on rising edges 2..25 of CS low, commits at edge 26, shifts SDO on falling edges
        always @(posedge DAC_CLK or negedge DAC_CLK) begin
            if (DAC_CLK) begin
                if (csn_a[g]) begin
                    n <= '0;
                end else begin
                    if (n >= 5'd1 && n <= 5'd24) sin <= {sin[22:0], sdi_a[g]};
                    if (n == 5'd25) begin
                        last_frame <= sin;
                        if (!sin[23] && sin[19:16] != 4'h0 && sin[19:16] <= 4'hB)
                            sreg[sin[19:16]] <= sin[15:0];
                        if (sin[23])
                            sout <= (sin[19:16] <= 4'hB) ? {4'h8, sin[19:16], sreg[sin[19:16]]} : 24'h0;
                    end
                    if (n != 5'd31) n <= n + 5'd1;
                end
            end else if (!csn_a[g] && n >= 5'd2) begin
                sout <= {sout[22:0], 1'b0};
            end
        end
        assign sdo_a[g] = sout[23];

        int lo_cur = 0, hi_cur = 0, last_lo = 0, last_hi = 0;
        int rsp_n = 0;
        logic [15:0] rsp_d = '0;
        logic        rsp_e = 1'b0;
        always @(negedge DAC_CLK) begin
            if (!csn_a[g]) begin
                lo_cur++;
                if (hi_cur != 0) begin last_hi = hi_cur; hi_cur = 0; end
            end else begin
                hi_cur++;
                if (lo_cur != 0) begin last_lo = lo_cur; lo_cur = 0; end
            end
            if (rspv_a[g]) begin rsp_n++; rsp_d = rspd_a[g]; rsp_e = rspe_a[g]; end
        end

        int acc_n = 0, acc_cyc = 0;
        always @(posedge DAC_CLK) begin
            if (c_valid[g] && ready_a[g]) begin acc_n++; acc_cyc = cyc; end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input int ch, input logic rd, input logic [3:0] addr, input logic [15:0] data);
        @(negedge DAC_CLK);
        c_valid[ch] = 1'b1; c_rd[ch] = rd; c_addr[ch] = addr; c_data[ch] = data;
        for (int i = 0; i < 300 && !ready_a[ch]; i++) @(negedge DAC_CLK);
        chk("issue_ready", 32'(ready_a[ch]), 32'd1);
        @(posedge DAC_CLK);
        #1;
        c_valid[ch] = 1'b0; c_rd[ch] = 1'b0; c_addr[ch] = 4'h0; c_data[ch] = 16'h0;
    endtask

    task automatic wait_idle(input int ch);
        for (int i = 0; i < 300 && (busy_a[ch] || !ready_a[ch]); i++) @(negedge DAC_CLK);
        chk("idle_timeout", 32'(busy_a[ch]), 32'd0);
        repeat (3) @(negedge DAC_CLK);
        #1;
    endtask

    int r0, a0, a1;

    initial begin
        for (int i = 0; i < 2; i++) begin
            c_valid[i] = 1'b0; c_rd[i] = 1'b0; c_addr[i] = 4'h0; c_data[i] = 16'h0;
        end
        repeat (3) @(negedge DAC_CLK);
        chk("rst_cs_n", 32'(csn_a[0]), 32'd1);
        chk("rst_sdi", 32'(sdi_a[0]), 32'd0);
        chk("rst_busy", 32'(busy_a[0]), 32'd0);
        chk("rst_rsp_valid", 32'(rspv_a[0]), 32'd0);
        chk("rst_rsp_data", 32'(rspd_a[0]), 32'd0);
        chk("rst_rsp_err", 32'(rspe_a[0]), 32'd0);
        SYS_RST = 1'b0;
        @(negedge DAC_CLK);
        chk("rst_ready", 32'(ready_a[0]), 32'd1);

        // 1: write DAC0
        issue(0, 1'b0, 4'h8, 16'h1234);
        wait_idle(0);
        chk("t1_frame", 32'(gch[0].last_frame), 32'h081234);
        chk("t1_cs_low", 32'(gch[0].last_lo), 32'd26);
        chk("t1_reg", 32'(gch[0].sreg[8]), 32'h1234);
        chk("t1_no_rsp", 32'(gch[0].rsp_n), 32'd0);

        // 2: read DEVICE_ID
        r0 = gch[0].rsp_n;
        issue(0, 1'b1, 4'h1, 16'h5555);
        wait_idle(0);
        chk("t2_rsp_cnt", 32'(gch[0].rsp_n - r0), 32'd1);
        chk("t2_rsp_data", 32'(gch[0].rsp_d), 32'hABCD);
        chk("t2_rsp_err", 32'(gch[0].rsp_e), 32'd0);
        chk("t2_gap", 32'(gch[0].last_hi), 32'd2);
        chk("t2_cs_low", 32'(gch[0].last_lo), 32'd26);
        chk("t2_echo_frame", 32'(gch[0].last_frame), 32'h000000);

        // 3: write GAIN then read GAIN with cmd_valid held
        @(negedge DAC_CLK);
        c_valid[0] = 1'b1; c_rd[0] = 1'b0; c_addr[0] = 4'h4; c_data[0] = 16'h0005;
        for (int i = 0; i < 300 && !ready_a[0]; i++) @(negedge DAC_CLK);
        @(posedge DAC_CLK);
        #1;
        a0 = gch[0].acc_n;
        a1 = gch[0].acc_cyc;
        c_rd[0] = 1'b1; c_data[0] = 16'hFFFF;
        for (int i = 0; i < 300 && gch[0].acc_n == a0; i++) @(negedge DAC_CLK);
        c_valid[0] = 1'b0; c_rd[0] = 1'b0; c_addr[0] = 4'h0; c_data[0] = 16'h0;
        chk("t3_accepts", 32'(gch[0].acc_n - a0), 32'd1);
        chk("t3_period", 32'(gch[0].acc_cyc - a1), 32'd28);
        r0 = gch[0].rsp_n;
        wait_idle(0);
        chk("t3_reg", 32'(gch[0].sreg[4]), 32'h0005);
        chk("t3_rsp_cnt", 32'(gch[0].rsp_n - r0), 32'd1);
        chk("t3_rsp_data", 32'(gch[0].rsp_d), 32'h0005);
        chk("t3_rsp_err", 32'(gch[0].rsp_e), 32'd0);
        chk("t3_no_extra", 32'(gch[0].acc_n - a0), 32'd1);

        // 4: illegal address read
        r0 = gch[0].rsp_n;
        issue(0, 1'b1, 4'hC, 16'h0000);
        wait_idle(0);
        chk("t4_rsp_cnt", 32'(gch[0].rsp_n - r0), 32'd1);
        chk("t4_rsp_data", 32'(gch[0].rsp_d), 32'h0000);
        chk("t4_rsp_err", 32'(gch[0].rsp_e), 32'd1);

        // 5: reset during a DAC1 write at E12
        r0 = gch[0].rsp_n;
        issue(0, 1'b0, 4'h9, 16'hBEEF);
        repeat (11) @(posedge DAC_CLK);
        #1;
        chk("t5_cs_low_before", 32'(csn_a[0]), 32'd0);
        @(posedge DAC_CLK);
        #1;
        SYS_RST = 1'b1;
        #1;
        chk("t5_cs_n", 32'(csn_a[0]), 32'd1);
        chk("t5_busy", 32'(busy_a[0]), 32'd0);
        repeat (2) @(negedge DAC_CLK);
        SYS_RST = 1'b0;
        repeat (30) @(negedge DAC_CLK);
        #1;
        chk("t5_reg", 32'(gch[0].sreg[9]), 32'h3344);
        chk("t5_no_rsp", 32'(gch[0].rsp_n - r0), 32'd0);
        chk("t5_ready", 32'(ready_a[0]), 32'd1);

        // 6: CS_GAP=1 read of DAC3
        issue(1, 1'b1, 4'hB, 16'h0000);
        wait_idle(1);
        chk("t6_rsp_cnt", 32'(gch[1].rsp_n), 32'd1);
        chk("t6_rsp_data", 32'(gch[1].rsp_d), 32'h7788);
        chk("t6_rsp_err", 32'(gch[1].rsp_e), 32'd0);
        chk("t6_gap", 32'(gch[1].last_hi), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
